fetch: RTL and testbench
========================

FETCH -- requirements
Module: fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 icache_addr  output  32  fetch address to icache, word aligned.
REQ-006 icache_req  output  1  fetch request to icache.
REQ-007 icache_data  input  32  instruction from icache, valid when icache_valid=1.
REQ-008 icache_valid  input  1  icache hit, combinational in the same cycle as icache_addr.
REQ-009 redirect_valid  input  1  branch/exception redirect from execute.
REQ-010 redirect_pc  input  32  redirect target.
REQ-011 out_valid  output  1  head entry valid toward decode.
REQ-012 out_pc  output  32  PC of head entry, 32'h0 when empty.
REQ-013 out_inst  output  32  instruction of head entry, 32'h0 when empty.
REQ-014 out_ready  input  1  decode accepts head; transfer when out_valid && out_ready.

Function
REQ-015 The block SHALL hold a PC register and drive icache_addr = {pc[31:2],2'b00} in RUN.
REQ-016 States SHALL be RUN, MISS, MISS_KILL.
REQ-017 In RUN, icache_req = !fifo_full && !redirect_valid.
REQ-018 In RUN, icache_req && icache_valid SHALL push {pc, icache_data} and advance pc by 4 in the same edge (zero-bubble on hit).
REQ-019 In RUN, icache_req && !icache_valid SHALL go to MISS with pc held.
REQ-020 In MISS and MISS_KILL, icache_addr and icache_req=1 SHALL stay constant until icache_valid; the address SHALL never change during an outstanding miss.
REQ-021 In MISS, icache_valid without redirect SHALL push the entry, advance pc by 4, and return to RUN.
REQ-022 redirect_valid in RUN SHALL flush the FIFO, set pc = {redirect_pc[31:2],2'b00}, push nothing, and stay in RUN.
REQ-023 redirect_valid in MISS or MISS_KILL SHALL flush the FIFO, save the aligned target (latest wins), and enter MISS_KILL.
REQ-024 In MISS_KILL, icache_valid SHALL discard icache_data, load pc from the saved target, and return to RUN.
REQ-025 out_valid SHALL be forced 0 in any cycle with redirect_valid=1; no pop occurs that cycle.
REQ-026 Push and pop in the same cycle SHALL leave the count unchanged; a push into a full FIFO SHALL not occur, by REQ-017.
REQ-027 FIFO order SHALL be strict in-order; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0.

Reset
REQ-029 While rst=1, the block SHALL set pc=RESET_PC, state=RUN, FIFO empty, saved target=0, icache_req=0, out_valid=0, out_pc=0, out_inst=0.
REQ-030 Reset asserted mid-miss SHALL abandon the miss; the first request after release SHALL use RESET_PC.

Configuration
REQ-031 Macro FETCH_JAL_PREDICT_EN: when defined, a pushed instruction with inst[6:0]=7'b1101111 (JAL) SHALL set next pc = pc + sign-extended J-immediate {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, taking priority over pc+4.
REQ-032 Without FETCH_JAL_PREDICT_EN, next pc after a push SHALL always be pc+4; JAL SHALL have no special handling.

Verification
REQ-033 Reset with RESET_PC=32'h100, icache always hitting, out_ready=1 -> out_pc sequence 100,104,108 on consecutive cycles, one per cycle.
REQ-034 out_ready=0 with constant hits -> exactly 2 entries (100,104) buffered; icache_req=0 afterwards; first out_ready=1 pops 100 and refetch resumes at 108.
REQ-035 Miss at 32'h200 for 5 cycles, then hit -> icache_addr stable at 200 for all 6 cycles; single entry pc=200 delivered.
REQ-036 Miss at 32'h200, redirect_pc=32'h403 during the miss -> addr held at 200; data on icache_valid discarded; next request addr=32'h400; no entry with pc=200 ever appears on out_*.
REQ-037 FIFO holding two entries, redirect_valid with redirect_pc=32'h80 -> out_valid=0 that cycle, FIFO empty next cycle, next out_pc=80.
REQ-038 With FETCH_JAL_PREDICT_EN, inst 32'h0100_006F (JAL x0,+16) at 32'h10 -> next fetch addr 32'h20; without the macro -> 32'h14.

Source files
------------

// File: rtl/fetch.sv
`default_nettype none
// ============================================================================
// Module   : fetch
// Purpose  : Instruction fetch front end. Holds the PC, issues word-aligned
//            requests to the icache, buffers {pc, inst} pairs in a small
//            in-order FIFO toward decode, and handles misses and redirects.
// Options  : FETCH_JAL_PREDICT_EN - when defined, a fetched JAL steers the
//            next fetch to its target instead of pc+4.
// Revision : 1.0 - initial release
// ============================================================================
module fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] icache_addr,
  output logic        icache_req,
  input  logic [31:0] icache_data,
  input  logic        icache_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  input  logic        out_ready
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] C_ONE_C = (AW+1)'(1);
  localparam logic [AW-1:0] C_ONE_P = AW'(1);

  typedef enum logic [1:0] {
    S_RUN       = 2'd0,
    S_MISS      = 2'd1,
    S_MISS_KILL = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   target_q, target_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_pc_q   [FIFO_DEPTH];
  logic [31:0]   mem_inst_q [FIFO_DEPTH];

  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;
  logic        w_flush;
  logic [31:0] w_pc_aligned;
  logic [31:0] w_redir_aligned;
  logic [31:0] w_next_pc;

  assign w_pc_aligned    = {pc_q[31:2], 2'b00};
  assign w_redir_aligned = {redirect_pc[31:2], 2'b00};
  assign w_full          = (count_q == C_DEPTH);
  assign w_empty         = (count_q == '0);

`ifdef FETCH_JAL_PREDICT_EN
  logic [31:0] w_jal_imm;
  logic        w_is_jal;
  assign w_jal_imm = {{11{icache_data[31]}}, icache_data[31], icache_data[19:12],
                      icache_data[20], icache_data[30:21], 1'b0};
  assign w_is_jal  = (icache_data[6:0] == 7'b1101111);
  assign w_next_pc = w_is_jal ? (w_pc_aligned + w_jal_imm) : (w_pc_aligned + 32'd4);
`else
  assign w_next_pc = w_pc_aligned + 32'd4;
`endif

  // The address is the held PC in every state, so it cannot move during a miss.
  assign icache_addr = w_pc_aligned;
  assign icache_req  = rst ? 1'b0 :
                       (state_q == S_RUN) ? (!w_full && !redirect_valid) : 1'b1;

  // Decode never sees the head in a redirect cycle; the flush takes it anyway.
  assign out_valid = !w_empty && !redirect_valid;
  assign out_pc    = w_empty ? 32'h0 : mem_pc_q[rd_ptr_q];
  assign out_inst  = w_empty ? 32'h0 : mem_inst_q[rd_ptr_q];
  assign w_pop     = out_valid && out_ready;

  // Next-state, PC and push/flush decisions.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    target_d = target_q;
    w_push   = 1'b0;
    w_flush  = 1'b0;
    case (state_q)
      S_RUN: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          pc_d    = w_redir_aligned;
        end else if (icache_req) begin
          if (icache_valid) begin
            w_push = 1'b1;
            pc_d   = w_next_pc;
          end else begin
            state_d = S_MISS;
          end
        end
      end
      S_MISS, S_MISS_KILL: begin
        if (redirect_valid) begin
          w_flush = 1'b1;
          if (icache_valid) begin
            // The outstanding miss completes in the redirect cycle itself:
            // nothing is left to kill, so resume directly at the new target.
            pc_d    = w_redir_aligned;
            state_d = S_RUN;
          end else begin
            target_d = w_redir_aligned;
            state_d  = S_MISS_KILL;
          end
        end else if (icache_valid) begin
          state_d = S_RUN;
          if (state_q == S_MISS) begin
            w_push = 1'b1;
            pc_d   = w_next_pc;
          end else begin
            pc_d = target_q;
          end
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + C_ONE_P;
      if (w_pop)  rd_ptr_d = rd_ptr_q + C_ONE_P;
      if (w_push && !w_pop)      count_d = count_q + C_ONE_C;
      else if (!w_push && w_pop) count_d = count_q - C_ONE_C;
    end
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      target_q <= 32'h0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage; contents are only observable while the count is non-zero.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_pc_q[wr_ptr_q]   <= w_pc_aligned;
      mem_inst_q[wr_ptr_q] <= icache_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch
// Purpose  : Self-checking bench for fetch: directed scenarios followed by a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] icache_addr;
  logic        icache_req;
  logic [31:0] icache_data;
  logic        icache_valid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready;
  logic        jal_mode;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  fetch #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .icache_addr   (icache_addr),
    .icache_req    (icache_req),
    .icache_data   (icache_data),
    .icache_valid  (icache_valid),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_ready     (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory image: a hash of the address, never a JAL opcode.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    logic [31:0] h;
    h = (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    return {h[31:7], 7'h13};
  endfunction

  assign icache_data = (jal_mode && icache_addr == 32'h10) ? 32'h0100_006F : mem_f(icache_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic rv, input logic [31:0] rp, input logic v, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rp;
    icache_valid   = v;
    out_ready      = rdy;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t        mq[$];
    logic [31:0] m_pc, m_tgt, rp, r, exp_jal;
    logic        m_wait, m_kill, e_req, e_ov;

    // ---------------- reset state
    rst = 1'b1;
    jal_mode = 1'b0;
    drv(1'b0, 32'h0, 1'b0, 1'b0);
    repeat (3) step();
    #3;
    chk("rst_req",  icache_req, 0);
    chk("rst_ov",   out_valid, 0);
    chk("rst_pc",   out_pc, 0);
    chk("rst_inst", out_inst, 0);
    chk("rst_addr", icache_addr, 32'h100);

    // ---------------- streaming hits, one entry per cycle
    step(); rst = 1'b0; drv(1'b0, 32'h0, 1'b1, 1'b1); #3;
    chk("b_req", icache_req, 1);
    chk("b_addr", icache_addr, 32'h100);
    chk("b_ov0", out_valid, 0);
    for (int k = 0; k < 3; k++) begin
      step(); #3;
      chk("b_ov", out_valid, 1);
      chk("b_pc", out_pc, 32'h100 + 32'(4 * k));
      chk("b_inst", out_inst, mem_f(32'h100 + 32'(4 * k)));
    end

    // ---------------- backpressure fills the buffer
    step(); rst = 1'b1; drv(1'b0, 32'h0, 1'b1, 1'b0);
    step(); rst = 1'b0; #3;
    chk("c_addr0", icache_addr, 32'h100);
    chk("c_req0", icache_req, 1);
    step(); #3;
    chk("c_addr1", icache_addr, 32'h104);
    chk("c_pc1", out_pc, 32'h100);
    step(); #3;
    chk("c_req_full", icache_req, 0);
    chk("c_ov_full", out_valid, 1);
    chk("c_pc_full", out_pc, 32'h100);
    step(); #3;
    chk("c_req_hold", icache_req, 0);
    out_ready = 1'b1; #1;
    chk("c_pop_pc", out_pc, 32'h100);
    step(); #3;
    chk("c_pc_next", out_pc, 32'h104);
    chk("c_req_resume", icache_req, 1);
    chk("c_addr_resume", icache_addr, 32'h108);

    // ---------------- miss held for five cycles then hit
    step(); drv(1'b1, 32'h200, 1'b0, 1'b1); #3;
    chk("d_ov_redir", out_valid, 0);
    chk("d_req_redir", icache_req, 0);
    step(); drv(1'b0, 32'h0, 1'b0, 1'b1);
    for (int m = 0; m < 5; m++) begin
      if (m > 0) step();
      #3;
      chk("d_addr_miss", icache_addr, 32'h200);
      chk("d_req_miss", icache_req, 1);
    end
    step(); icache_valid = 1'b1; #3;
    chk("d_addr_hit", icache_addr, 32'h200);
    step(); icache_valid = 1'b0; #3;
    chk("d_ov", out_valid, 1);
    chk("d_pc", out_pc, 32'h200);
    chk("d_inst", out_inst, mem_f(32'h200));
    step(); #3;
    chk("d_ov_single", out_valid, 0);
    chk("d_addr_204", icache_addr, 32'h204);
    // reset while the miss at 204 is outstanding
    rst = 1'b1; #1;
    chk("d_rst_req", icache_req, 0);
    step(); rst = 1'b0; #3;
    chk("d_rst_addr", icache_addr, 32'h100);
    chk("d_rst_req1", icache_req, 1);

    // ---------------- redirect during a miss kills the returned data
    drv(1'b1, 32'h200, 1'b0, 1'b0); #1;
    step(); drv(1'b0, 32'h0, 1'b0, 1'b0); #3;
    chk("e_addr", icache_addr, 32'h200);
    step(); drv(1'b1, 32'h403, 1'b0, 1'b0); #3;
    chk("e_addr_k", icache_addr, 32'h200);
    chk("e_req_k", icache_req, 1);
    step(); drv(1'b0, 32'h0, 1'b0, 1'b0); #3;
    chk("e_addr_k2", icache_addr, 32'h200);
    chk("e_req_k2", icache_req, 1);
    step(); icache_valid = 1'b1; #3;
    chk("e_addr_kv", icache_addr, 32'h200);
    chk("e_ov_kv", out_valid, 0);
    step(); icache_valid = 1'b0; #3;
    chk("e_addr_new", icache_addr, 32'h400);
    chk("e_ov_new", out_valid, 0);
    chk("e_req_new", icache_req, 1);
    step(); icache_valid = 1'b1; #3;
    chk("e_addr_400", icache_addr, 32'h400);

    // ---------------- redirect flushes a full buffer
    step(); #3;
    chk("f_pc400", out_pc, 32'h400);
    chk("f_addr404", icache_addr, 32'h404);
    step(); #3;
    chk("f_req_full", icache_req, 0);
    chk("f_ov_full", out_valid, 1);
    drv(1'b1, 32'h80, 1'b1, 1'b1); #1;
    chk("f_ov_redir", out_valid, 0);
    step(); drv(1'b0, 32'h0, 1'b1, 1'b1); #3;
    chk("f_ov_empty", out_valid, 0);
    chk("f_pc_empty", out_pc, 0);
    chk("f_addr80", icache_addr, 32'h80);
    step(); drv(1'b0, 32'h0, 1'b0, 1'b1); #3;
    chk("f_ov80", out_valid, 1);
    chk("f_pc80", out_pc, 32'h80);

    // ---------------- JAL at 0x10
    step(); rst = 1'b1; drv(1'b0, 32'h0, 1'b0, 1'b0);
    step(); rst = 1'b0; drv(1'b1, 32'h10, 1'b0, 1'b1); #3;
    step(); drv(1'b0, 32'h0, 1'b1, 1'b1); jal_mode = 1'b1; #3;
    chk("g_addr10", icache_addr, 32'h10);
    step(); drv(1'b0, 32'h0, 1'b0, 1'b1); #3;
    chk("g_pc", out_pc, 32'h10);
    chk("g_inst", out_inst, 32'h0100_006F);
`ifdef FETCH_JAL_PREDICT_EN
    exp_jal = 32'h20;
`else
    exp_jal = 32'h14;
`endif
    chk("g_next_addr", icache_addr, exp_jal);
    jal_mode = 1'b0;

    // ---------------- randomized run against the reference model
    step(); rst = 1'b1; drv(1'b0, 32'h0, 1'b0, 1'b0);
    step();
    m_pc = 32'h100; m_tgt = 32'h0; m_wait = 1'b0; m_kill = 1'b0;
    mq.delete();
    for (int c = 0; c < 600; c++) begin
      if (c > 0) step();
      else rst = 1'b0;
      rp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                       : 32'($urandom_range(0, 32'hFFF));
      drv($urandom_range(0, 99) < 8, rp, $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 60);
      #3;
      e_req = m_wait ? 1'b1 : ((mq.size() < 2) && !redirect_valid);
      e_ov  = (mq.size() > 0) && !redirect_valid;
      chk("rnd_req", icache_req, e_req);
      chk("rnd_addr", icache_addr, m_pc);
      chk("rnd_ov", out_valid, e_ov);
      if (mq.size() == 0) begin
        chk("rnd_pc_empty", out_pc, 0);
        chk("rnd_inst_empty", out_inst, 0);
      end else if (e_ov) begin
        chk("rnd_pc", out_pc, mq[0].pc);
        chk("rnd_inst", out_inst, mq[0].inst);
      end
      // advance the model across the coming edge
      if (redirect_valid) begin
        mq.delete();
        r = {rp[31:2], 2'b00};
        if (m_wait && icache_valid) begin
          m_pc = r; m_wait = 1'b0; m_kill = 1'b0;
        end else if (m_wait) begin
          m_tgt = r; m_kill = 1'b1;
        end else begin
          m_pc = r;
        end
      end else begin
        if (e_ov && out_ready) void'(mq.pop_front());
        if (e_req && icache_valid) begin
          if (m_kill) m_pc = m_tgt;
          else begin
            mq.push_back('{pc: m_pc, inst: mem_f(m_pc)});
            m_pc = m_pc + 32'd4;
          end
          m_wait = 1'b0; m_kill = 1'b0;
        end else if (e_req) begin
          m_wait = 1'b1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
